// File: rtl/codemem_loader_pkg.sv
// rtl/codemem_loader_pkg.sv - shared types and constants for the code-memory bootloader
package codemem_loader_pkg;

  localparam int unsigned CODE_ADDR_W       = 6;
  localparam int unsigned CODE_WORD_W       = 17;
  localparam logic [7:0]  DEFAULT_SYNC_BYTE = 8'hA5;

  // Packet parser states: header bytes, three bytes per word, one write cycle, trailer
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_COUNT,
    ST_B0,
    ST_B1,
    ST_B2,
    ST_WRITE,
    ST_CSUM
  } state_e;

  // Assemble a code word: multicycle flag on top, instruction high byte, low byte
  function automatic logic [CODE_WORD_W-1:0] pack_word(input logic       flag,
                                                       input logic [7:0] hi,
                                                       input logic [7:0] lo);
    return {flag, hi, lo};
  endfunction

endpackage

// File: rtl/codemem_loader_if.sv
// rtl/codemem_loader_if.sv - byte-stream valid/ready handshake between source and loader
interface codemem_loader_if;

  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;

  // Byte source side (UART receiver or host bridge)
  modport master (
    output rx_data,
    output rx_valid,
    input  rx_ready
  );

  // Loader side
  modport slave (
    input  rx_data,
    input  rx_valid,
    output rx_ready
  );

endinterface

// File: rtl/codemem_loader.sv
// rtl/codemem_loader.sv - framed byte-stream loader driving the 64x17 code-memory write port
module codemem_loader
  import codemem_loader_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 65535,
  parameter logic [7:0]  SYNC_BYTE      = DEFAULT_SYNC_BYTE
) (
  input  logic                   clock,
  input  logic                   reset_n,
  codemem_loader_if.slave        rx,
  output logic                   c1,
  output logic [CODE_ADDR_W-1:0] write_select,
  output logic [CODE_WORD_W-1:0] inp,
  output logic                   cpu_hold,
  output logic                   done,
  output logic                   error
);

  localparam logic [15:0] TMO_LIMIT = 16'(TIMEOUT_CYCLES);

  state_e                 state_q, state_d;
  logic [CODE_ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]             cnt_q, cnt_d;     // remaining words; 0 encodes 256
  logic [7:0]             csum_q, csum_d;
  logic [15:0]            tmo_q, tmo_d;
  logic                   b0_q, b0_d;
  logic [7:0]             b1_q, b1_d;
  logic [CODE_ADDR_W-1:0] wsel_q, wsel_d;
  logic [CODE_WORD_W-1:0] inp_q, inp_d;
  logic                   done_q, done_d;
  logic                   error_q, error_d;

  logic                   rx_ready_w;
  logic                   xfer;
  logic                   in_packet;
  logic [15:0]            tmo_inc;

  // The loader stalls the source only during the single write cycle
  assign rx_ready_w = (state_q != ST_WRITE);
  assign xfer       = rx.rx_valid && rx_ready_w;
  // Timeout is only armed while waiting for a byte inside a packet
  assign in_packet  = (state_q != ST_IDLE) && (state_q != ST_WRITE);
  assign tmo_inc    = tmo_q + 16'd1;

  // State and datapath registers, all cleared asynchronously
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      csum_q  <= '0;
      tmo_q   <= '0;
      b0_q    <= 1'b0;
      b1_q    <= '0;
      wsel_q  <= '0;
      inp_q   <= '0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      csum_q  <= csum_d;
      tmo_q   <= tmo_d;
      b0_q    <= b0_d;
      b1_q    <= b1_d;
      wsel_q  <= wsel_d;
      inp_q   <= inp_d;
      done_q  <= done_d;
      error_q <= error_d;
    end
  end

  // Packet parser: next state, word assembly, checksum, and inter-byte timeout
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    csum_d  = csum_q;
    tmo_d   = '0;
    b0_d    = b0_q;
    b1_d    = b1_q;
    wsel_d  = wsel_q;
    inp_d   = inp_q;
    done_d  = 1'b0;
    error_d = error_q;

    if (in_packet && !xfer) begin
      tmo_d = tmo_inc;
    end

    case (state_q)
      ST_IDLE: begin
        if (xfer && (rx.rx_data == SYNC_BYTE)) begin
          state_d = ST_ADDR;
          csum_d  = '0;
          error_d = 1'b0;
        end
      end
      ST_ADDR: begin
        if (xfer) begin
          addr_d  = rx.rx_data[CODE_ADDR_W-1:0];
          csum_d  = csum_q ^ rx.rx_data;
          state_d = ST_COUNT;
        end
      end
      ST_COUNT: begin
        if (xfer) begin
          cnt_d   = rx.rx_data;
          csum_d  = csum_q ^ rx.rx_data;
          state_d = ST_B0;
        end
      end
      ST_B0: begin
        if (xfer) begin
          b0_d    = rx.rx_data[0];
          csum_d  = csum_q ^ rx.rx_data;
          state_d = ST_B1;
        end
      end
      ST_B1: begin
        if (xfer) begin
          b1_d    = rx.rx_data;
          csum_d  = csum_q ^ rx.rx_data;
          state_d = ST_B2;
        end
      end
      ST_B2: begin
        if (xfer) begin
          wsel_d  = addr_q;
          inp_d   = pack_word(b0_q, b1_q, rx.rx_data);
          csum_d  = csum_q ^ rx.rx_data;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        // Address wraps naturally at 64; a count of 0 runs 256 words
        addr_d  = addr_q + 1'b1;
        cnt_d   = cnt_q - 8'd1;
        state_d = (cnt_q == 8'd1) ? ST_CSUM : ST_B0;
      end
      ST_CSUM: begin
        if (xfer) begin
          if (rx.rx_data == csum_q) begin
            done_d = 1'b1;
          end else begin
            error_d = 1'b1;
          end
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Abandon the packet when the source goes quiet; a half-built word is dropped
    if (in_packet && !xfer && (tmo_inc == TMO_LIMIT)) begin
      state_d = ST_IDLE;
      error_d = 1'b1;
      tmo_d   = '0;
    end
  end

  assign rx.rx_ready  = rx_ready_w;
  assign c1           = (state_q == ST_WRITE);
  assign write_select = wsel_q;
  assign inp          = inp_q;
  assign cpu_hold     = (state_q != ST_IDLE);
  assign done         = done_q;
  assign error        = error_q;

endmodule

// File: tb/tb_codemem_loader.sv
// tb/tb_codemem_loader.sv - directed self-checking bench for codemem_loader
module tb_codemem_loader;

  logic        clk;
  logic        rst_n;
  logic        c1;
  logic [5:0]  write_select;
  logic [16:0] inp;
  logic        cpu_hold;
  logic        done;
  logic        error;

  int n_cmp = 0;
  int n_bad = 0;

  logic [5:0]  wa_log[$];
  logic [16:0] wd_log[$];
  int          done_cnt  = 0;
  int          bad_ready = 0;

  logic [7:0]  pkt[$];
  int          wbase;
  int          dbase;

  codemem_loader_if rx_if();

  codemem_loader #(
    .TIMEOUT_CYCLES(8),
    .SYNC_BYTE     (8'hA5)
  ) dut (
    .clock       (clk),
    .reset_n     (rst_n),
    .rx          (rx_if.slave),
    .c1          (c1),
    .write_select(write_select),
    .inp         (inp),
    .cpu_hold    (cpu_hold),
    .done        (done),
    .error       (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observe write pulses and done pulses mid-cycle
  always @(negedge clk) begin
    if (rst_n) begin
      if (c1) begin
        wa_log.push_back(write_select);
        wd_log.push_back(inp);
        if (rx_if.rx_ready) bad_ready++;
      end
      if (done) done_cnt++;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Present one byte after an idle gap; returns #1 after the edge that took it
  task automatic send(input logic [7:0] b, input int gap);
    bit acc;
    acc = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    rx_if.rx_data  = b;
    rx_if.rx_valid = 1'b1;
    for (int i = 0; i < 16 && !acc; i++) begin
      @(negedge clk);
      if (rx_if.rx_ready === 1'b1) acc = 1'b1;
      @(posedge clk);
      #1;
    end
    rx_if.rx_valid = 1'b0;
    if (!acc) begin
      n_cmp++;
      n_bad++;
      $error("FAIL accept byte 0x%0h observed=stalled expected=accepted", b);
    end
  endtask

  task automatic send_pkt(input int maxgap);
    for (int i = 0; i < pkt.size(); i++) begin
      send(pkt[i], (maxgap == 0) ? 0 : int'($urandom_range(0, maxgap)));
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst_n          = 1'b0;
    rx_if.rx_data  = 8'h00;
    rx_if.rx_valid = 1'b0;
    #1;
    check("reset_outputs", {c1, write_select, inp, cpu_hold, done, error}, 32'h0);
    check("reset_rx_ready", rx_if.rx_ready, 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    tick(1);

    // Single word at address 5
    wbase = wa_log.size();
    dbase = done_cnt;
    send(8'hA5, 0);
    check("single_hold_after_sync", cpu_hold, 1);
    pkt = '{8'h05, 8'h01, 8'h01, 8'h12, 8'h34};
    send_pkt(0);
    check("single_c1_after_b2", c1, 1);
    check("single_ready_low_in_write", rx_if.rx_ready, 0);
    check("single_wsel", write_select, 32'd5);
    check("single_inp", inp, 32'h11234);
    send(8'h23, 0);
    check("single_done", done, 1);
    check("single_hold_dropped", cpu_hold, 0);
    check("single_error", error, 0);
    tick(1);
    check("single_done_one_cycle", done, 0);
    check("single_nwrites", wa_log.size() - wbase, 1);
    check("single_addr", wa_log[wbase], 32'd5);
    check("single_data", wd_log[wbase], 32'h11234);
    check("single_ndone", done_cnt - dbase, 1);

    // Three words from address 62, wrapping to 0
    wbase = wa_log.size();
    dbase = done_cnt;
    pkt = '{8'hA5, 8'h3E, 8'h03, 8'h01, 8'hAA, 8'h55, 8'h00, 8'h12, 8'h34,
            8'hFF, 8'hFF, 8'hFF, 8'h1A};
    send_pkt(0);
    tick(1);
    check("wrap_nwrites", wa_log.size() - wbase, 3);
    check("wrap_addr0", wa_log[wbase], 32'd62);
    check("wrap_data0", wd_log[wbase], 32'h1AA55);
    check("wrap_addr1", wa_log[wbase+1], 32'd63);
    check("wrap_data1", wd_log[wbase+1], 32'h01234);
    check("wrap_addr2", wa_log[wbase+2], 32'd0);
    check("wrap_data2", wd_log[wbase+2], 32'h1FFFF);
    check("wrap_ndone", done_cnt - dbase, 1);
    check("wrap_error", error, 0);

    // Bad checksum: word still lands, error sticks until the next sync
    wbase = wa_log.size();
    dbase = done_cnt;
    pkt = '{8'hA5, 8'h05, 8'h01, 8'h01, 8'h12, 8'h34, 8'h00};
    send_pkt(0);
    check("badcs_error", error, 1);
    check("badcs_done", done, 0);
    tick(1);
    check("badcs_nwrites", wa_log.size() - wbase, 1);
    check("badcs_data", wd_log[wbase], 32'h11234);
    check("badcs_ndone", done_cnt - dbase, 0);
    send(8'h00, 0);
    check("badcs_error_sticky", error, 1);
    send(8'hA5, 0);
    check("badcs_error_cleared_on_sync", error, 0);

    // Timeout mid-word: stall after B1 of the first word
    wbase = wa_log.size();
    pkt = '{8'h00, 8'h02, 8'h00, 8'h11};
    send_pkt(0);
    tick(7);
    check("tmo_not_yet_error", error, 0);
    check("tmo_not_yet_hold", cpu_hold, 1);
    tick(1);
    check("tmo_error", error, 1);
    check("tmo_hold_dropped", cpu_hold, 0);
    check("tmo_ready", rx_if.rx_ready, 1);
    tick(2);
    check("tmo_no_write", wa_log.size() - wbase, 0);

    // Noise before sync, then a packet with random source gaps
    send(8'h00, 2);
    send(8'hFF, 1);
    check("noise_no_hold", cpu_hold, 0);
    check("noise_error_kept", error, 1);
    wbase = wa_log.size();
    dbase = done_cnt;
    pkt = '{8'hA5, 8'h10, 8'h02, 8'h01, 8'hDE, 8'hAD, 8'h00, 8'hBE, 8'hEF, 8'h31};
    send_pkt(3);
    tick(1);
    check("noise_nwrites", wa_log.size() - wbase, 2);
    check("noise_addr0", wa_log[wbase], 32'h10);
    check("noise_data0", wd_log[wbase], 32'h1DEAD);
    check("noise_addr1", wa_log[wbase+1], 32'h11);
    check("noise_data1", wd_log[wbase+1], 32'h0BEEF);
    check("noise_ndone", done_cnt - dbase, 1);
    check("noise_error", error, 0);
    check("hold_wsel", write_select, 32'h11);
    check("hold_inp", inp, 32'h0BEEF);

    // Reset after B1 of the second word
    wbase = wa_log.size();
    pkt = '{8'hA5, 8'h20, 8'h02, 8'h01, 8'h11, 8'h22, 8'h00, 8'h33};
    send_pkt(0);
    check("rstmid_wsel_before", write_select, 32'h20);
    #2;
    rst_n = 1'b0;
    #1;
    check("rstmid_outputs", {c1, write_select, inp, cpu_hold, done, error}, 32'h0);
    check("rstmid_ready", rx_if.rx_ready, 1);
    check("rstmid_nwrites", wa_log.size() - wbase, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    tick(1);
    wbase = wa_log.size();
    dbase = done_cnt;
    pkt = '{8'hA5, 8'h07, 8'h01, 8'h00, 8'hAB, 8'hCD, 8'h60};
    send_pkt(0);
    tick(1);
    check("after_rst_nwrites", wa_log.size() - wbase, 1);
    check("after_rst_addr", wa_log[wbase], 32'd7);
    check("after_rst_data", wd_log[wbase], 32'h0ABCD);
    check("after_rst_ndone", done_cnt - dbase, 1);
    check("after_rst_error", error, 0);

    check("no_accept_during_write", bad_ready, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
